// File: rtl/probador_compuertas.sv
// Self-checking stimulus/monitor for a two-input gate bank: steps a/b through
// 00,01,10,11, samples the seven gate outputs after a settle time, logs mismatches.
module probador_compuertas #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_out,
    output logic             b_out,
    input  logic             i_and,
    input  logic             i_not,
    input  logic             i_nand,
    input  logic             i_or,
    input  logic             i_nor,
    input  logic             i_xor,
    input  logic             i_xnor,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [6:0]       err_map,
    output logic [3:0]       err_vec
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    state_t           state, state_nx;
    logic [1:0]       vec;
    logic [1:0]       vec_inc;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       obs;
    logic [6:0]       exp_bits;
    logic [6:0]       mism;
    logic [6:0]       map_nx;
    logic             va, vb;

    // Bit order matches err_map: AND, NOT, NAND, OR, NOR, XOR, XNOR from bit 0 up.
    assign obs = {i_xnor, i_xor, i_nor, i_or, i_nand, i_not, i_and};

    always_comb begin
        va       = vec[1];
        vb       = vec[0];
        exp_bits = {~(va ^ vb), va ^ vb, ~(va | vb), va | vb, ~(va & vb), ~va, va & vb};
        mism     = obs ^ exp_bits;
        map_nx   = err_map | mism;
        vec_inc  = vec + 2'd1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (start) state_nx = ST_SETTLE;
            ST_SETTLE: if (cnt == '0) state_nx = ST_CHECK;
            ST_CHECK:  state_nx = (vec == 2'd3) ? ST_DONE : ST_SETTLE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            vec     <= '0;
            cnt     <= '0;
            a_out   <= 1'b0;
            b_out   <= 1'b0;
            err_map <= '0;
            err_vec <= '0;
            pass    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err_map <= '0;
                        err_vec <= '0;
                        pass    <= 1'b0;
                        vec     <= 2'd0;
                        cnt     <= CNT_LOAD;
                        a_out   <= 1'b0;
                        b_out   <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                ST_CHECK: begin
                    err_map <= map_nx;
                    if (|mism) err_vec[vec] <= 1'b1;
                    // pass is resolved here so it is already valid during the DONE cycle.
                    if (vec == 2'd3) begin
                        pass <= (map_nx == '0);
                    end else begin
                        vec   <= vec_inc;
                        a_out <= vec_inc[1];
                        b_out <= vec_inc[0];
                        cnt   <= CNT_LOAD;
                    end
                end
                ST_DONE: begin
                    vec   <= '0;
                    a_out <= 1'b0;
                    b_out <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/probador_compuertas.md
# probador_compuertas

- Sequential self-checking driver/monitor for the two-input logic-gate bank: AND, NOT, NAND, OR, NOR, XOR and XNOR outputs from a shared `a1`/`b1` pair.
- On `start` it drives all four input combinations onto the bank and waits a programmable settle time per combination.
- It then samples the seven gate outputs, compares them against internally computed expected values, and reports a per-gate and per-vector error map plus a pass flag.
- It sits on the input/output side of the gate bank as its stimulus source and result consumer, used for board bring-up and lab self-test.

## Interface
- `SETTLE`, default 2: cycles each vector is held before sampling. Legal range is 1 to 2^CNT_W−1.
- `CNT_W`, default 4: width of the settle counter.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  run request, sampled only in IDLE.
- `a_out`  out  1  drives gate-bank input a1; registered.
- `b_out`  out  1  drives gate-bank input b1; registered.
- `i_and`, `i_not`, `i_nand`, `i_or`, `i_nor`, `i_xor`, `i_xnor`  in  1 each  gate-bank outputs under test.
- `busy`  out  1  high from the cycle after start is accepted through the DONE cycle.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  1 when the last completed run had no mismatches; held until the next start.
- `err_map`  out  7  sticky per-gate mismatch bits: bit0 AND, bit1 NOT, bit2 NAND, bit3 OR, bit4 NOR, bit5 XOR, bit6 XNOR.
- `err_vec`  out  4  sticky per-vector mismatch bits; bit k corresponds to vector k.

## Operation
- Vector k is in 0..3: `a_out` = k[1], `b_out` = k[0]. Order is 00, 01, 10, 11.
- Expected values:
  - and = a&b
  - not = ~a
  - nand = ~(a&b)
  - or = a|b
  - nor = ~(a|b)
  - xor = a^b
  - xnor = ~(a^b)
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - Outputs: `busy`=0, `a_out`=`b_out`=0.
  - On `start`=1 at a clock edge: clear `err_map`, `err_vec` and `pass`; set vector=0; load `a_out`/`b_out` for vector 0; load counter=SETTLE−1; go to SETTLE.
- SETTLE:
  - Hold `a_out`/`b_out`.
  - When counter=0, go to CHECK; otherwise decrement.
- CHECK (one cycle):
  - Compare the seven inputs with expected values for the current vector.
  - OR the mismatch bits into `err_map`.
  - Set `err_vec[k]` if any bit mismatches.
  - If k=3, go to DONE. Otherwise increment k, drive the new `a_out`/`b_out` at the same edge, reload the counter, and go to SETTLE.
- DONE (one cycle):
  - `done`=1 and `pass` = (`err_map`==0), using the final map including the vector-3 compare.
  - Next state is IDLE.
  - `a_out`/`b_out` return to 0 on entering IDLE.
- `start` is ignored outside IDLE; there is no queuing.
- `err_map`, `err_vec` and `pass` are held from DONE until the next accepted `start`.

## Timing
- Reset: when `rst_n`=0 at an edge, go to IDLE from any state. All outputs are 0 and the vector and counter are 0. A run aborted mid-operation is discarded and `done` does not pulse.
- Let E0 be the edge at which `start` is accepted.
  - Vector k is driven from edge E0 + k(SETTLE+1).
  - Vector k is sampled at the end of cycle E0 + k(SETTLE+1) + SETTLE.
- `done` is high for the single cycle beginning at edge E0 + 4(SETTLE+1). With SETTLE=2, that is edge E12.
- `busy` is high from E0 through the DONE cycle inclusive.
- With `start` held high, runs repeat with period 4(SETTLE+1)+2 cycles: the DONE cycle plus one IDLE cycle. With SETTLE=2 the period is 14.
- Inputs are sampled only in CHECK; glitches during SETTLE are ignored.

## Test plan
- Golden bank (correct gates wired to `a_out`/`b_out`), SETTLE=2, pulse `start`:
  - `a_out`/`b_out` step 00, 01, 10, 11, each held 3 cycles.
  - `done` pulses at E12.
  - `pass`=1, `err_map`=7'b0000000, `err_vec`=4'b0000.
- `i_xor` stuck at 0, others golden:
  - `err_map`=7'b0100000, `err_vec`=4'b0110, `pass`=0.
- `i_not` wired to a instead of ~a:
  - `err_map`=7'b0000010, `err_vec`=4'b1111, `pass`=0.
- Reset mid-run: assert `rst_n`=0 at edge E5.
  - Next cycle: `busy`=0, `a_out`=`b_out`=0, `err_map`=0, `pass`=0.
  - No `done` pulse.
  - A later `start` runs a full golden pass with `pass`=1.
- Re-start rules:
  - Pulse `start` again at E3 and E8 while busy: ignored, and `done` still occurs only at E12.
  - Hold `start` high continuously: `done` pulses at E12, E26, E40.
  - Results are cleared at each restart and correct after each run.
- SETTLE=1 with golden bank: `done` at E8, `pass`=1.
